mul2_tournament_scorer: RTL

Fitness stage downstream of the evolved bit-sliced 2-bit multiplier individuals. It drives the fixed 16-lane exhaustive stimulus (a1, a0, b1, b0) into a candidate, accepts each candidate's four 16-bit outputs through a valid/ready handshake, and scores them against the golden 2x2 product. Scoring is pipelined. Over a tournament of TOUR_SIZE candidates it keeps the best one and emits the winner's id and score for the selection logic.

---
 rtl/mul2_eval_pkg.sv | 27 ++
 rtl/mul2_tournament_scorer_popcount16.sv | 14 +
 rtl/mul2_tournament_scorer.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/mul2_eval_pkg.sv
// Shared constants and types for scoring evolved 2x2-bit multiplier candidates
// against the 16-lane exhaustive stimulus.
package mul2_eval_pkg;

    // Lane i encodes a = i[3:2], b = i[1:0]
    localparam logic [15:0] STIM_A1 = 16'hFF00;
    localparam logic [15:0] STIM_A0 = 16'hF0F0;
    localparam logic [15:0] STIM_B1 = 16'hCCCC;
    localparam logic [15:0] STIM_B0 = 16'hAAAA;

    localparam logic [15:0] EXP_Y3 = 16'h8000;
    localparam logic [15:0] EXP_Y2 = 16'h4C00;
    localparam logic [15:0] EXP_Y1 = 16'h6AC0;
    localparam logic [15:0] EXP_Y0 = 16'hA0A0;

    localparam int unsigned SCORE_W = 7;

    typedef logic [SCORE_W-1:0] score_t;

    localparam score_t MAX_SCORE = 7'd64;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } round_state_e;

endpackage

// File: rtl/mul2_tournament_scorer_popcount16.sv
// Combinational population count of a 16-bit word.
module popcount16 (
    input  logic [15:0] data_i,
    output logic [4:0]  count_o
);

    always_comb begin
        count_o = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            count_o = count_o + {4'b0000, data_i[i]};
        end
    end

endmodule

// File: rtl/mul2_tournament_scorer.sv
// Tournament fitness scorer: drives exhaustive stimulus, scores each candidate's
// bit-sliced outputs against the golden product and reports the round winner.
module mul2_tournament_scorer
    import mul2_eval_pkg::*;
#(
    parameter int unsigned TOUR_SIZE = 4,
    parameter int unsigned ID_W      = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [15:0]     stim_a1,
    output logic [15:0]     stim_a0,
    output logic [15:0]     stim_b1,
    output logic [15:0]     stim_b0,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [ID_W-1:0] in_id,
    input  logic [15:0]     in_y3,
    input  logic [15:0]     in_y2,
    input  logic [15:0]     in_y1,
    input  logic [15:0]     in_y0,
    output logic            win_valid,
    input  logic            win_ready,
    output logic [ID_W-1:0] win_id,
    output logic [6:0]      win_score,
    output logic            win_perfect
);

    localparam int unsigned CNT_W = $clog2(TOUR_SIZE + 1);

    round_state_e state_q, state_d;
    logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
    logic [15:0] stim_a1_q, stim_a0_q, stim_b1_q, stim_b0_q;

    logic            s0_valid_q, s0_last_q, s0_first_q;
    logic [ID_W-1:0] s0_id_q;
    logic [15:0]     s0_y3_q, s0_y2_q, s0_y1_q, s0_y0_q;

    logic            s1_valid_q, s1_last_q, s1_first_q;
    logic [ID_W-1:0] s1_id_q;
    logic [4:0]      s1_pc3_q, s1_pc2_q, s1_pc1_q, s1_pc0_q;
    logic [4:0]      pc3, pc2, pc1, pc0;

    logic [ID_W-1:0] best_id_q, best_id_d;
    score_t          best_score_q, best_score_d;
    logic [ID_W-1:0] win_id_q;
    score_t          win_score_q;
    logic            win_perfect_q;

    logic   accept, acc_last, take, round_done, win_taken;
    score_t err_sum, score;

    assign in_ready   = rst_n && (state_q == COLLECT) && (acc_cnt_q < CNT_W'(TOUR_SIZE));
    assign accept     = in_valid && in_ready;
    assign acc_last   = (acc_cnt_q == CNT_W'(TOUR_SIZE - 1));
    assign win_taken  = (state_q == HOLD) && win_ready;
    assign round_done = s1_valid_q && s1_last_q;

    popcount16 u_pc3 (.data_i(s0_y3_q ^ EXP_Y3), .count_o(pc3));
    popcount16 u_pc2 (.data_i(s0_y2_q ^ EXP_Y2), .count_o(pc2));
    popcount16 u_pc1 (.data_i(s0_y1_q ^ EXP_Y1), .count_o(pc1));
    popcount16 u_pc0 (.data_i(s0_y0_q ^ EXP_Y0), .count_o(pc0));

    always_comb begin
        err_sum = {2'b00, s1_pc3_q} + {2'b00, s1_pc2_q} + {2'b00, s1_pc1_q} + {2'b00, s1_pc0_q};
        score   = MAX_SCORE - err_sum;
        // Strictly-greater keeps the earliest candidate on ties
        take         = s1_valid_q && (s1_first_q || (score > best_score_q));
        best_id_d    = take ? s1_id_q : best_id_q;
        best_score_d = take ? score   : best_score_q;
    end

    always_comb begin
        state_d   = state_q;
        acc_cnt_d = acc_cnt_q;
        if (accept) begin
            acc_cnt_d = acc_cnt_q + CNT_W'(1);
        end
        case (state_q)
            COLLECT: if (round_done) state_d = HOLD;
            HOLD: begin
                if (win_ready) begin
                    state_d   = COLLECT;
                    acc_cnt_d = '0;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= COLLECT;
            acc_cnt_q     <= '0;
            s0_valid_q    <= 1'b0;
            s1_valid_q    <= 1'b0;
            best_id_q     <= '0;
            best_score_q  <= '0;
            win_id_q      <= '0;
            win_score_q   <= '0;
            win_perfect_q <= 1'b0;
            stim_a1_q     <= STIM_A1;
            stim_a0_q     <= STIM_A0;
            stim_b1_q     <= STIM_B1;
            stim_b0_q     <= STIM_B0;
        end else begin
            state_q    <= state_d;
            acc_cnt_q  <= acc_cnt_d;
            s0_valid_q <= accept;
            s1_valid_q <= s0_valid_q;
            if (win_taken) begin
                best_id_q    <= '0;
                best_score_q <= '0;
            end else begin
                best_id_q    <= best_id_d;
                best_score_q <= best_score_d;
            end
            if (round_done) begin
                win_id_q      <= best_id_d;
                win_score_q   <= best_score_d;
                win_perfect_q <= (best_score_d == MAX_SCORE);
            end
        end
    end

    // Payload registers are qualified by the valid pipeline and need no reset
    always_ff @(posedge clk) begin
        if (accept) begin
            s0_id_q    <= in_id;
            s0_last_q  <= acc_last;
            s0_first_q <= (acc_cnt_q == '0);
            s0_y3_q    <= in_y3;
            s0_y2_q    <= in_y2;
            s0_y1_q    <= in_y1;
            s0_y0_q    <= in_y0;
        end
        if (s0_valid_q) begin
            s1_id_q    <= s0_id_q;
            s1_last_q  <= s0_last_q;
            s1_first_q <= s0_first_q;
            s1_pc3_q   <= pc3;
            s1_pc2_q   <= pc2;
            s1_pc1_q   <= pc1;
            s1_pc0_q   <= pc0;
        end
    end

    assign stim_a1     = stim_a1_q;
    assign stim_a0     = stim_a0_q;
    assign stim_b1     = stim_b1_q;
    assign stim_b0     = stim_b0_q;
    assign win_valid   = (state_q == HOLD);
    assign win_id      = win_id_q;
    assign win_score   = win_score_q;
    assign win_perfect = win_perfect_q;

endmodule
